// File: rtl/rfphoenix_operand_fetch_pkg.sv
// rfPhoenixPkg: shared types for the rfPhoenix pipeline.
package rfPhoenixPkg;
   typedef logic [31:0] Instruction;
   typedef logic [31:0] Value;
   typedef logic [5:0]  Regspec;
   localparam int NREGS = 64;
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} of_state_e;
endpackage

// File: rtl/rfphoenix_bypass_mux.sv
// rfphoenix_bypass_mux: resolves one source operand.
// Inputs:  spec_i is the source specifier.
//          ex_* and wb_* are the in-flight results.
//          rf_i is the register-file read data.
// Output:  val_o is the resolved operand value.
module rfphoenix_bypass_mux
   import rfPhoenixPkg::*;
(
   input  logic [5:0]  spec_i,
   input  logic        ex_v_i,
   input  logic        ex_ld_i,
   input  logic [5:0]  ex_rt_i,
   input  logic [31:0] ex_res_i,
   input  logic        wb_v_i,
   input  logic [5:0]  wb_rt_i,
   input  logic [31:0] wb_res_i,
   input  logic [31:0] rf_i,
   output logic [31:0] val_o
);
   // r0 reads as zero even if a stage claims to write it; EX is younger than WB.
   always_comb
      val_o = (spec_i == '0)                                ? '0 :
              (ex_v_i && !ex_ld_i && ex_rt_i == spec_i)     ? ex_res_i :
              (wb_v_i && wb_rt_i == spec_i)                 ? wb_res_i : rf_i;
endmodule

// File: rtl/rfphoenix_operand_fetch.sv
// rfphoenix_operand_fetch: operand fetch with EX/WB bypass and load-use stall.
// Decode side: dc_v_i/dc_rdy_o handshake, with ir, source/dest specifiers and imm.
// Register file: rf_r*_o are the read addresses, and rf_*_i is the same-cycle data.
// Bypass: ex_* and wb_* are the in-flight results; ex_ld_i marks a pending load.
// ALU side: of_v_o/of_rdy_i handshake, with the registered ir, a, b, c, imm and rt.
// stall_cnt_o counts load-use stall cycles and saturates at all-ones.
module rfphoenix_operand_fetch
   import rfPhoenixPkg::*;
#(
   parameter int NREGS = 64,
   parameter int CNTW  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush_i,
   input  logic                     dc_v_i,
   output logic                     dc_rdy_o,
   input  logic [31:0]              dc_ir_i,
   input  logic [$clog2(NREGS)-1:0] dc_ra_i,
   input  logic [$clog2(NREGS)-1:0] dc_rb_i,
   input  logic [$clog2(NREGS)-1:0] dc_rc_i,
   input  logic [$clog2(NREGS)-1:0] dc_rt_i,
   input  logic [31:0]              dc_imm_i,
   output logic [$clog2(NREGS)-1:0] rf_ra_o,
   output logic [$clog2(NREGS)-1:0] rf_rb_o,
   output logic [$clog2(NREGS)-1:0] rf_rc_o,
   input  logic [31:0]              rf_a_i,
   input  logic [31:0]              rf_b_i,
   input  logic [31:0]              rf_c_i,
   input  logic                     ex_v_i,
   input  logic [$clog2(NREGS)-1:0] ex_rt_i,
   input  logic [31:0]              ex_res_i,
   input  logic                     ex_ld_i,
   input  logic                     wb_v_i,
   input  logic [$clog2(NREGS)-1:0] wb_rt_i,
   input  logic [31:0]              wb_res_i,
   output logic                     of_v_o,
   input  logic                     of_rdy_i,
   output logic [31:0]              of_ir_o,
   output logic [31:0]              of_a_o,
   output logic [31:0]              of_b_o,
   output logic [31:0]              of_c_o,
   output logic [31:0]              of_imm_o,
   output logic [$clog2(NREGS)-1:0] of_rt_o,
   output logic [CNTW-1:0]          stall_cnt_o
);
   of_state_e       state_q, state_d;
   logic [31:0]     ir_q, ir_d, a_q, a_d, b_q, b_d, c_q, c_d, imm_q, imm_d;
   logic [5:0]      rt_q, rt_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [31:0]     a_val, b_val, c_val;
   logic            hazard, xfer;

   assign rf_ra_o = dc_ra_i;
   assign rf_rb_o = dc_rb_i;
   assign rf_rc_o = dc_rc_i;

   rfphoenix_bypass_mux u_mux_a (.spec_i(dc_ra_i), .ex_v_i, .ex_ld_i, .ex_rt_i, .ex_res_i,
                                 .wb_v_i, .wb_rt_i, .wb_res_i, .rf_i(rf_a_i), .val_o(a_val));
   rfphoenix_bypass_mux u_mux_b (.spec_i(dc_rb_i), .ex_v_i, .ex_ld_i, .ex_rt_i, .ex_res_i,
                                 .wb_v_i, .wb_rt_i, .wb_res_i, .rf_i(rf_b_i), .val_o(b_val));
   rfphoenix_bypass_mux u_mux_c (.spec_i(dc_rc_i), .ex_v_i, .ex_ld_i, .ex_rt_i, .ex_res_i,
                                 .wb_v_i, .wb_rt_i, .wb_res_i, .rf_i(rf_c_i), .val_o(c_val));

   always_comb begin
      hazard   = dc_v_i && ex_v_i && ex_ld_i && ex_rt_i != '0 &&
                 (ex_rt_i == dc_ra_i || ex_rt_i == dc_rb_i || ex_rt_i == dc_rc_i);
      dc_rdy_o = (state_q == EMPTY || of_rdy_i) && !hazard && !flush_i;
      xfer     = dc_v_i && dc_rdy_o;
      // xfer is already false under flush, so flush only needs to win over hold.
      state_d  = xfer ? FULL : (flush_i || of_rdy_i) ? EMPTY : state_q;
      ir_d     = xfer ? dc_ir_i  : ir_q;
      a_d      = xfer ? a_val    : a_q;
      b_d      = xfer ? b_val    : b_q;
      c_d      = xfer ? c_val    : c_q;
      imm_d    = xfer ? dc_imm_i : imm_q;
      rt_d     = xfer ? dc_rt_i  : rt_q;
      cnt_d    = (hazard && !flush_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         imm_q   <= '0;
         rt_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         imm_q   <= imm_d;
         rt_q    <= rt_d;
         cnt_q   <= cnt_d;
      end
   end

   assign of_v_o      = (state_q == FULL);
   assign of_ir_o     = ir_q;
   assign of_a_o      = a_q;
   assign of_b_o      = b_q;
   assign of_c_o      = c_q;
   assign of_imm_o    = imm_q;
   assign of_rt_o     = rt_q;
   assign stall_cnt_o = cnt_q;
endmodule

// File: tb/tb_rfphoenix_operand_fetch.sv
// tb_rfphoenix_operand_fetch: directed self-checking bench for rfphoenix_operand_fetch.
module tb_rfphoenix_operand_fetch;
   logic        clk = 0, rst = 1, flush_i = 0, dc_v_i = 0, dc_rdy_o;
   logic [31:0] dc_ir_i = 0, dc_imm_i = 0, rf_a_i = 0, rf_b_i = 0, rf_c_i = 0;
   logic [5:0]  dc_ra_i = 0, dc_rb_i = 0, dc_rc_i = 0, dc_rt_i = 0;
   logic [5:0]  rf_ra_o, rf_rb_o, rf_rc_o, ex_rt_i = 0, wb_rt_i = 0, of_rt_o;
   logic        ex_v_i = 0, ex_ld_i = 0, wb_v_i = 0, of_v_o, of_rdy_i = 1;
   logic [31:0] ex_res_i = 0, wb_res_i = 0;
   logic [31:0] of_ir_o, of_a_o, of_b_o, of_c_o, of_imm_o;
   logic [15:0] stall_cnt_o;
   int          n_cmp = 0, n_bad = 0;

   rfphoenix_operand_fetch #(.NREGS(64), .CNTW(16)) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i), .dc_v_i(dc_v_i), .dc_rdy_o(dc_rdy_o),
      .dc_ir_i(dc_ir_i), .dc_ra_i(dc_ra_i), .dc_rb_i(dc_rb_i), .dc_rc_i(dc_rc_i),
      .dc_rt_i(dc_rt_i), .dc_imm_i(dc_imm_i), .rf_ra_o(rf_ra_o), .rf_rb_o(rf_rb_o),
      .rf_rc_o(rf_rc_o), .rf_a_i(rf_a_i), .rf_b_i(rf_b_i), .rf_c_i(rf_c_i),
      .ex_v_i(ex_v_i), .ex_rt_i(ex_rt_i), .ex_res_i(ex_res_i), .ex_ld_i(ex_ld_i),
      .wb_v_i(wb_v_i), .wb_rt_i(wb_rt_i), .wb_res_i(wb_res_i), .of_v_o(of_v_o),
      .of_rdy_i(of_rdy_i), .of_ir_o(of_ir_o), .of_a_o(of_a_o), .of_b_o(of_b_o),
      .of_c_o(of_c_o), .of_imm_o(of_imm_o), .of_rt_o(of_rt_o), .stall_cnt_o(stall_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1;
      check("rst_v", {31'b0, of_v_o}, 32'h0);
      check("rst_ir", of_ir_o, 32'h0);
      check("rst_a", of_a_o, 32'h0);
      check("rst_cnt", {16'b0, stall_cnt_o}, 32'h0);
      check("rst_rdy", {31'b0, dc_rdy_o}, 32'h1);
      tick();
      rst = 0;
      // plain register-file read
      dc_v_i = 1; dc_ir_i = 32'h11; dc_ra_i = 5; dc_rt_i = 3; dc_imm_i = 32'h7; rf_a_i = 32'h1234;
      #1;
      check("rf_addr", {26'b0, rf_ra_o}, 32'd5);
      check("plain_rdy", {31'b0, dc_rdy_o}, 32'h1);
      tick();
      check("plain_v", {31'b0, of_v_o}, 32'h1);
      check("plain_a", of_a_o, 32'h1234);
      check("plain_ir", of_ir_o, 32'h11);
      check("plain_rt", {26'b0, of_rt_o}, 32'd3);
      check("plain_imm", of_imm_o, 32'h7);
      // EX beats WB on the same register
      dc_ir_i = 32'h12; dc_ra_i = 0; dc_rb_i = 7; rf_b_i = 32'hBEEF;
      ex_v_i = 1; ex_rt_i = 7; ex_res_i = 32'hAAAA0000; wb_v_i = 1; wb_rt_i = 7; wb_res_i = 32'h5555;
      tick();
      check("ex_prio_b", of_b_o, 32'hAAAA0000);
      check("r0_a", of_a_o, 32'h0);
      // r0 ignores EX bypass; WB-only bypass on b; plain RF on a
      dc_ir_i = 32'h13; dc_ra_i = 6; rf_a_i = 32'h66; dc_rb_i = 4; wb_rt_i = 4;
      dc_rc_i = 0; rf_c_i = 32'h77; ex_rt_i = 0; ex_res_i = 32'hFFFFFFFF;
      tick();
      check("r0_c", of_c_o, 32'h0);
      check("wb_b", of_b_o, 32'h5555);
      check("rf_a", of_a_o, 32'h66);
      // load to r0 is not a hazard
      ex_ld_i = 1; ex_rt_i = 0; dc_ra_i = 0; dc_rb_i = 0; wb_v_i = 0;
      #1;
      check("ld_r0_rdy", {31'b0, dc_rdy_o}, 32'h1);
      // load-use stall on r9 for two cycles
      dc_ir_i = 32'h14; ex_rt_i = 9; dc_ra_i = 9; rf_a_i = 32'h1111;
      #1;
      check("lu_rdy0", {31'b0, dc_rdy_o}, 32'h0);
      tick();
      check("lu_rdy1", {31'b0, dc_rdy_o}, 32'h0);
      check("lu_v1", {31'b0, of_v_o}, 32'h0);
      check("lu_cnt1", {16'b0, stall_cnt_o}, 32'd1);
      tick();
      check("lu_cnt2", {16'b0, stall_cnt_o}, 32'd2);
      ex_v_i = 0; ex_ld_i = 0; wb_v_i = 1; wb_rt_i = 9; wb_res_i = 32'hCAFE;
      #1;
      check("lu_rdy_clr", {31'b0, dc_rdy_o}, 32'h1);
      tick();
      check("lu_v", {31'b0, of_v_o}, 32'h1);
      check("lu_a", of_a_o, 32'hCAFE);
      check("lu_cnt_hold", {16'b0, stall_cnt_o}, 32'd2);
      // backpressure for three cycles
      wb_v_i = 0; of_rdy_i = 0; dc_ir_i = 32'h22; dc_ra_i = 5; rf_a_i = 32'h2222;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("bp_rdy", {31'b0, dc_rdy_o}, 32'h0);
         tick();
         check("bp_v", {31'b0, of_v_o}, 32'h1);
         check("bp_ir", of_ir_o, 32'h14);
         check("bp_a", of_a_o, 32'hCAFE);
         rf_a_i = 32'h3333;
      end
      of_rdy_i = 1; rf_a_i = 32'h2222;
      #1;
      check("bp_rel_rdy", {31'b0, dc_rdy_o}, 32'h1);
      tick();
      check("b2b_ir0", of_ir_o, 32'h22);
      check("b2b_a0", of_a_o, 32'h2222);
      dc_ir_i = 32'h33;
      tick();
      check("b2b_v1", {31'b0, of_v_o}, 32'h1);
      check("b2b_ir1", of_ir_o, 32'h33);
      // flush while FULL with decode valid, plus a hazard that must not count
      flush_i = 1; of_rdy_i = 0; dc_ir_i = 32'h44; ex_v_i = 1; ex_ld_i = 1; ex_rt_i = 5;
      #1;
      check("fl_rdy", {31'b0, dc_rdy_o}, 32'h0);
      tick();
      check("fl_v", {31'b0, of_v_o}, 32'h0);
      check("fl_ir", of_ir_o, 32'h33);
      check("fl_cnt", {16'b0, stall_cnt_o}, 32'd2);
      // simultaneous flush and of_rdy_i ends EMPTY
      ex_v_i = 0; ex_ld_i = 0; flush_i = 0; of_rdy_i = 1; dc_ir_i = 32'h55;
      tick();
      check("pre_fr_v", {31'b0, of_v_o}, 32'h1);
      flush_i = 1; dc_v_i = 0;
      tick();
      check("fr_v", {31'b0, of_v_o}, 32'h0);
      // async reset mid-cycle while FULL with a stall count
      flush_i = 0; dc_v_i = 1; dc_ir_i = 32'h66;
      tick();
      check("pre_rst_v", {31'b0, of_v_o}, 32'h1);
      #2 rst = 1;
      #1;
      check("arst_v", {31'b0, of_v_o}, 32'h0);
      check("arst_cnt", {16'b0, stall_cnt_o}, 32'h0);
      check("arst_ir", of_ir_o, 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/rfphoenix_operand_fetch.md
# rfphoenix_operand_fetch

Operand-fetch stage that sits directly upstream of the execute ALU. It accepts one decoded instruction per cycle from decode and reads the register file. It forwards results still in flight from the EX and WB stages and stalls on load-use hazards. It then presents a registered `ir`, `a`, `b`, `c`, `imm` bundle to the ALU through a valid/ready handshake.

## Interface
Parameters:
- `NREGS`, 64: architectural register count; specifier width is log2(NREGS) = 6.
- `CNTW`, 16: width of the stall performance counter.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush_i`  in  1  pipeline flush.
- `dc_v_i`  in  1  decode bundle valid.
- `dc_rdy_o`  out  1  stage can accept the decode bundle.
- `dc_ir_i`  in  Instruction  decoded instruction word.
- `dc_ra_i`, `dc_rb_i`, `dc_rc_i`  in  6 each  source register specifiers.
- `dc_rt_i`  in  6  destination register specifier.
- `dc_imm_i`  in  Value  immediate, already sign-extended by decode.
- `rf_ra_o`, `rf_rb_o`, `rf_rc_o`  out  6 each  register-file read addresses, driven combinationally from the `dc_r*_i` inputs.
- `rf_a_i`, `rf_b_i`, `rf_c_i`  in  Value each  register-file read data, combinational same-cycle read.
- `ex_v_i`, `ex_rt_i`, `ex_res_i`, `ex_ld_i`  in  1/6/Value/1  EX-stage result; `ex_ld_i` means EX holds a load whose data is not yet available.
- `wb_v_i`, `wb_rt_i`, `wb_res_i`  in  1/6/Value  WB-stage result.
- `of_v_o`  out  1  ALU bundle valid.
- `of_rdy_i`  in  1  ALU stage accepts the bundle.
- `of_ir_o`  out  Instruction  registered instruction.
- `of_a_o`, `of_b_o`, `of_c_o`, `of_imm_o`  out  Value each  registered operands.
- `of_rt_o`  out  6  registered destination specifier.
- `stall_cnt_o`  out  CNTW  saturating count of hazard-stall cycles.

## Operation
- **Operand select.** Each source specifier is resolved independently, in priority order:
  - specifier == 0 gives 32'h0, always, regardless of any bypass;
  - else `ex_v_i & ~ex_ld_i & ex_rt_i == spec` gives `ex_res_i`;
  - else `wb_v_i & wb_rt_i == spec` gives `wb_res_i`;
  - else the register-file data.
- **Hazard.** `hazard = dc_v_i & ex_v_i & ex_ld_i & ex_rt_i != 0`, and `ex_rt_i` matches any of `ra`, `rb` or `rc`. All three sources are always checked; decode zeroes unused specifiers.
- **Accept.** `dc_rdy_o = (~of_v_o | of_rdy_i) & ~hazard & ~flush_i`. A transfer occurs when `dc_v_i & dc_rdy_o`.
- **Output register.** On a transfer, load `ir`, the three resolved operands, `imm` and `rt`, and set `of_v_o`.
  - Else if `of_rdy_i`, clear `of_v_o`.
  - Else hold all outputs unchanged. Held operands are final and are never re-resolved.
- **Flush.** `flush_i` clears `of_v_o` at the next edge and blocks acceptance in that cycle. The data registers keep their values.
- **Stall counter.** Increments on each cycle where `hazard & ~flush_i` holds, and saturates at all-ones.
- **States.** EMPTY (`of_v_o` = 0) and FULL (`of_v_o` = 1).
  - EMPTY to FULL on a transfer.
  - FULL to FULL on a transfer with `of_rdy_i`, or while `~of_rdy_i`.
  - FULL to EMPTY on `of_rdy_i` with no transfer, or on `flush_i`.
- **Equal-priority sources.** If EX and WB both target the same register, EX wins, being the younger result.

## Timing
- **Reset.** `of_v_o` = 0, `of_ir_o` = 0, `of_a_o`/`of_b_o`/`of_c_o`/`of_imm_o` = 0, `of_rt_o` = 0, `stall_cnt_o` = 0. `dc_rdy_o` follows its combinational equation.
- **Latency.** 1 cycle, from the accept edge to `of_v_o`.
- **Throughput.** 1 instruction per cycle when `of_rdy_i` is held high.
- **Combinational paths.** `dc_rdy_o` depends combinationally on `of_rdy_i`, `flush_i` and the EX inputs; there is no registered ready.
- **Load-use.** A load-use dependency stalls exactly as long as `ex_ld_i` stays asserted for the matching register. The bundle is accepted in the first cycle the hazard clears, taking its operand from WB or EX.
- **Reset mid-operation.** Reset asserted mid-transfer discards the bundle immediately, because the reset is asynchronous.
- **Simultaneous flush and `of_rdy_i`.** The stage ends EMPTY.

## Structure
- **Shared package `rfPhoenixPkg`.** `Instruction` and `Value` already live there. Add to it:
  - `typedef logic [5:0] Regspec`;
  - the constant `NREGS`.
- **Sub-module `rfphoenix_bypass_mux`.** Purely combinational; it takes a specifier, the EX/WB bypass sources and the register-file data, and returns a Value. It is instantiated three times, once each for `a`, `b` and `c`.
- **Top level.** Holds the hazard detect, the handshake, the output register and the stall counter.

## Test plan
- **Plain RF read.** `ra`=5, rf_a=32'h1234, no bypass, `of_rdy_i`=1 -> next cycle `of_v_o`=1, `of_a_o`=32'h1234.
- **EX over WB priority.** `rb`=7; EX writes r7=32'hAAAA0000 (not a load) and WB writes r7=32'h5555 in the same cycle -> `of_b_o`=32'hAAAA0000.
- **r0 ignores bypass.** `rc`=0 while EX writes r0=32'hFFFFFFFF -> `of_c_o`=0.
- **Load-use stall.**
  - Stimulus: EX holds a load to r9 with `ex_ld_i`=1 for 2 cycles; decode presents `ra`=9.
  - Required: `dc_rdy_o`=0 for 2 cycles and `stall_cnt_o`=2.
  - Then, with the load in WB and `wb_res_i`=32'hCAFE, the bundle is accepted and `of_a_o`=32'hCAFE.
- **Backpressure.** `of_rdy_i`=0 for 3 cycles while FULL -> outputs unchanged, `dc_rdy_o`=0. Then `of_rdy_i`=1 with a new `dc_v_i` -> back-to-back transfer with no bubble.
- **Flush and async reset.** Assert `flush_i` while FULL with `dc_v_i`=1 -> next cycle `of_v_o`=0 and nothing is accepted. Assert `rst` asynchronously mid-cycle -> `of_v_o` and `stall_cnt_o` drop to 0 without waiting for a clock edge.
